text_stream_sequencer: RTL and testbench

TEXT_STREAM_SEQUENCER -- requirements
Module: text_stream_sequencer

---
 rtl/text_stream_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_text_stream_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_stream_sequencer.sv
`timescale 1ns/1ps
// text_stream_sequencer
// Walks a character ROM and offers each character to a display sink.
// Four modes: stop, continuous loop, single pass, and word step (one word
// per step request). Optional pacing inserts idle cycles between characters.
//
// Sink handshake (char_valid / char_ready):
//   char_valid rises with char_out already stable, and both stay unchanged
//   until a rising clk edge samples char_valid=1 and char_ready=1; that edge
//   is the accept. char_valid is never withdrawn before accept (only reset
//   can drop it). char_ready may toggle freely.
//
// ROM interface: rom_en is a one-cycle read strobe with rom_addr; rom_data
// is expected to be valid in the cycle right after rom_en.
module text_stream_sequencer #(
  parameter int STR_LEN = 51,
  parameter int ADDR_W  = 8,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic [DIV_W-1:0]  tick_div,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    OFFER = 3'd3,
    PACE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_LOOP   = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_WORD   = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(STR_LEN - 1);
  localparam logic [7:0]        SPACE     = 8'h20;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               armed_q, armed_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  // Attributes of the last accepted character, kept for the decision
  // taken at the end of PACE.
  logic               last_q, last_d;
  logic               space_q, space_d;
  logic               rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [7:0]         char_out_q, char_out_d;
  logic               char_valid_q, char_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               decide;
  logic               dec_last;
  logic               dec_space;
  logic               go_fetch;

  // Next-state and next-output computation; outputs are registered so they
  // follow the state they belong to exactly.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    space_d      = space_q;
    rom_en_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    char_out_d   = char_out_q;
    char_valid_d = 1'b0;
    done_d       = 1'b0;
    decide       = 1'b0;
    dec_last     = 1'b0;
    dec_space    = 1'b0;
    go_fetch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mode == MODE_STOP) begin
          ptr_d   = '0;
          armed_d = 1'b1;
        end
        if (ena && ((mode == MODE_LOOP) ||
                    (mode == MODE_SINGLE && armed_q) ||
                    (mode == MODE_WORD && step))) begin
          go_fetch = 1'b1;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        char_out_d   = rom_data;
        char_valid_d = 1'b1;
        state_d      = OFFER;
      end
      OFFER: begin
        char_valid_d = 1'b1;
        if (char_ready) begin
          char_valid_d = 1'b0;
          ptr_d        = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
          last_d       = (ptr_q == LAST_ADDR);
          space_d      = (char_out_q == SPACE);
          if (tick_div != '0) begin
            cnt_d   = tick_div - DIV_W'(1);
            state_d = PACE;
          end else begin
            decide    = 1'b1;
            dec_last  = (ptr_q == LAST_ADDR);
            dec_space = (char_out_q == SPACE);
          end
        end
      end
      PACE: begin
        if (cnt_q == '0) begin
          decide    = 1'b1;
          dec_last  = last_q;
          dec_space = space_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Post-character decision: mode/ena are only looked at here and in IDLE.
    if (decide) begin
      if (!ena || mode == MODE_STOP) begin
        state_d = IDLE;
      end else if (mode == MODE_SINGLE && dec_last) begin
        done_d  = 1'b1;
        armed_d = 1'b0;
        state_d = IDLE;
      end else if (mode == MODE_WORD && (dec_last || dec_space)) begin
        state_d = IDLE;
      end else begin
        go_fetch = 1'b1;
      end
    end

    if (go_fetch) begin
      state_d    = FETCH;
      rom_en_d   = 1'b1;
      rom_addr_d = ptr_d;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      armed_q      <= 1'b1;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      space_q      <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      space_q      <= space_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_text_stream_sequencer.sv
`timescale 1ns/1ps
// Directed bench for text_stream_sequencer with a behavioural 51-byte ROM.
module tb_text_stream_sequencer;

  localparam int STR_LEN = 51;
  localparam int ADDR_W  = 8;
  localparam int DIV_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              step = 1'b0;
  logic [DIV_W-1:0]  tick_div = '0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic [7:0]        char_out;
  logic              char_valid;
  logic              char_ready = 1'b1;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  text_stream_sequencer #(
    .STR_LEN(STR_LEN),
    .ADDR_W (ADDR_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode      (mode),
    .step      (step),
    .tick_div  (tick_div),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .char_out  (char_out),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  logic [7:0]           rom [0:STR_LEN-1];
  logic [8*STR_LEN-1:0] rom_str;

  always @(posedge clk) begin
    if (rom_en && int'(rom_addr) < STR_LEN) rom_data <= rom[int'(rom_addr)];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int               fetch_cyc_q[$];
  logic [ADDR_W-1:0] fetch_addr_q[$];
  logic [7:0]       acc_q[$];
  int               acc_cyc_q[$];
  logic [7:0]       exp_q[$];
  int               done_cnt = 0;
  int               done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        fetch_cyc_q.push_back(cyc);
        fetch_addr_q.push_back(rom_addr);
      end
      if (char_valid && char_ready) begin
        acc_q.push_back(char_out);
        acc_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    fetch_cyc_q.delete();
    fetch_addr_q.delete();
    acc_q.delete();
    acc_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b0; mode = 2'b00; step = 1'b0; tick_div = '0; char_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_fetch(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (fetch_cyc_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_acc(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (char_valid) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; mode = 2'b01; char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
    checks++; if (char_out !== 8'h00) begin errors++; $display("FAIL reset_char_out: got %h want 00", char_out); end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid: got %b want 0", char_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    mode = 2'b00; ena = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_loop();
    bit ok;
    int bad_sp;
    int bad_ch;
    do_reset();
    ena = 1'b1; mode = 2'b01; tick_div = '0;
    wait_acc(53, 400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL loop_timeout: got %0d accepts want 53", acc_q.size()); end
    checks++; if (acc_q[0] !== 8'h54) begin errors++; $display("FAIL loop_char0: got %h want 54", acc_q[0]); end
    checks++; if (acc_q[1] !== 8'h61) begin errors++; $display("FAIL loop_char1: got %h want 61", acc_q[1]); end
    checks++; if (acc_q[2] !== 8'h6A) begin errors++; $display("FAIL loop_char2: got %h want 6a", acc_q[2]); end
    checks++; if (fetch_addr_q[0] !== 8'd0) begin errors++; $display("FAIL loop_addr0: got %0d want 0", fetch_addr_q[0]); end
    checks++; if (fetch_addr_q[50] !== 8'd50) begin errors++; $display("FAIL loop_addr50: got %0d want 50", fetch_addr_q[50]); end
    checks++; if (fetch_addr_q[51] !== 8'd0) begin errors++; $display("FAIL loop_wrap_addr: got %0d want 0", fetch_addr_q[51]); end
    checks++; if (acc_q[51] !== 8'h54) begin errors++; $display("FAIL loop_wrap_char: got %h want 54", acc_q[51]); end
    bad_sp = 0;
    for (int i = 1; i < 52; i++) if (fetch_cyc_q[i] - fetch_cyc_q[i-1] != 3) bad_sp++;
    checks++; if (bad_sp !== 0) begin errors++; $display("FAIL loop_spacing: got %0d gaps not equal 3, want 0", bad_sp); end
    bad_ch = 0;
    for (int i = 0; i < 53; i++) if (acc_q[i] !== rom[i % STR_LEN]) bad_ch++;
    checks++; if (bad_ch !== 0) begin errors++; $display("FAIL loop_stream: got %0d wrong chars want 0", bad_ch); end
    mode = 2'b00;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    ena = 1'b1; mode = 2'b10;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout: got done_cnt %0d want 1", done_cnt); end
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (acc_q.size() !== 51) begin errors++; $display("FAIL single_count: got %0d want 51", acc_q.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_cycles: got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== acc_cyc_q[50] + 1) begin errors++; $display("FAIL single_done_time: got %0d want %0d", done_cyc, acc_cyc_q[50] + 1); end
    checks++; if (acc_q[50] !== 8'h63) begin errors++; $display("FAIL single_last_char: got %h want 63", acc_q[50]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    checks++; if (fetch_cyc_q.size() !== 51) begin errors++; $display("FAIL single_no_refetch: got %0d fetches want 51", fetch_cyc_q.size()); end
    @(posedge clk); #1 mode = 2'b00;
    repeat (2) @(posedge clk);
    #1 clear_logs();
    mode = 2'b10;
    wait_fetch(1, 10, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_rearm: got no fetch want fetch"); end
    checks++; if (fetch_addr_q[0] !== 8'd0) begin errors++; $display("FAIL single_rearm_addr: got %0d want 0", fetch_addr_q[0]); end
    mode = 2'b00;
  endtask

  task automatic test_word();
    do_reset();
    ena = 1'b1; mode = 2'b11; step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (acc_q.size() !== 10) begin errors++; $display("FAIL word1_count: got %0d want 10", acc_q.size()); end
    checks++; if (acc_q[0] !== 8'h54) begin errors++; $display("FAIL word1_first: got %h want 54", acc_q[0]); end
    checks++; if (acc_q[9] !== 8'h20) begin errors++; $display("FAIL word1_last: got %h want 20", acc_q[9]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL word1_idle: got %b want 0", busy); end
    clear_logs();
    exp_q = '{8'h54, 8'h61, 8'h63, 8'h61, 8'h6E, 8'h61, 8'h20};
    step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL word2_count: got %0d want %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL word2_char%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL word2_idle: got %b want 0", busy); end
    mode = 2'b00;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] held;
    do_reset();
    char_ready = 1'b0; ena = 1'b1; mode = 2'b01;
    wait_valid(20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_no_valid: got none want char_valid"); end
    held = char_out;
    checks++; if (held !== 8'h54) begin errors++; $display("FAIL bp_char: got %h want 54", held); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (char_valid !== 1'b1 || char_out !== held)
        begin errors++; $display("FAIL bp_hold%0d: got valid %b char %h want 1 %h", k, char_valid, char_out, held); end
    end
    @(posedge clk); #1 char_ready = 1'b1;
    wait_fetch(2, 10, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %0d fetches want 2", fetch_cyc_q.size()); end
    checks++; if (fetch_addr_q[1] !== 8'd1) begin errors++; $display("FAIL bp_ptr_step: got %0d want 1", fetch_addr_q[1]); end
    checks++; if (acc_cyc_q[0] !== fetch_cyc_q[0] + 7) begin errors++; $display("FAIL bp_accept_cycle: got %0d want %0d", acc_cyc_q[0], fetch_cyc_q[0] + 7); end
    mode = 2'b00;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_pace_abort();
    bit ok;
    do_reset();
    tick_div = 16'd4; ena = 1'b1; mode = 2'b01;
    wait_fetch(3, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pace_timeout: got %0d fetches want 3", fetch_cyc_q.size()); end
    checks++; if (fetch_cyc_q[1] - fetch_cyc_q[0] !== 7) begin errors++; $display("FAIL pace_gap1: got %0d want 7", fetch_cyc_q[1] - fetch_cyc_q[0]); end
    checks++; if (fetch_cyc_q[2] - fetch_cyc_q[1] !== 7) begin errors++; $display("FAIL pace_gap2: got %0d want 7", fetch_cyc_q[2] - fetch_cyc_q[1]); end
    char_ready = 1'b0;
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_no_valid: got none want char_valid"); end
    @(posedge clk); #1 mode = 2'b00;
    @(posedge clk); #1 char_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL abort_delivered: got %0d accepts want 3", acc_q.size()); end
    checks++; if (acc_q[2] !== 8'h6A) begin errors++; $display("FAIL abort_char: got %h want 6a", acc_q[2]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
    checks++; if (fetch_cyc_q.size() !== 3) begin errors++; $display("FAIL abort_no_fetch: got %0d want 3", fetch_cyc_q.size()); end
    clear_logs();
    tick_div = '0; mode = 2'b01;
    wait_fetch(1, 10, ok);
    checks++; if (fetch_addr_q[0] !== 8'd0) begin errors++; $display("FAIL abort_ptr_cleared: got %0d want 0", fetch_addr_q[0]); end
    mode = 2'b00;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    ena = 1'b1; mode = 2'b01;
    wait_fetch(3, 20, ok);
    char_ready = 1'b0;
    wait_valid(10, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL areset_no_valid: got none want char_valid"); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL areset_valid_drop: got %b want 0", char_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    checks++; if (char_out !== 8'h00) begin errors++; $display("FAIL areset_char: got %h want 00", char_out); end
    #2 rst_n = 1'b1;
    char_ready = 1'b1;
    clear_logs();
    wait_acc(1, 10, ok);
    checks++; if (fetch_addr_q[0] !== 8'd0) begin errors++; $display("FAIL areset_restart_addr: got %0d want 0", fetch_addr_q[0]); end
    checks++; if (acc_q[0] !== 8'h54) begin errors++; $display("FAIL areset_restart_char: got %h want 54", acc_q[0]); end
    mode = 2'b00;
    repeat (5) @(posedge clk);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rom_str = "Tajumulco Tacana Santa Maria Atitlan Fuego Agua Pac";
    for (int i = 0; i < STR_LEN; i++) rom[i] = rom_str[8*(STR_LEN-1-i) +: 8];
    test_reset();
    test_loop();
    test_single();
    test_word();
    test_backpressure();
    test_pace_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
